// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its helpers.
package fetch_sequencer_pkg;

  localparam int unsigned FS_REG_WIDTH   = 8;
  localparam int unsigned FS_ADDR_WIDTH  = 16;
  localparam int unsigned FS_STATE_WIDTH = 4;
  localparam int unsigned FS_CNT_WIDTH   = 2;

  localparam logic [FS_ADDR_WIDTH-1:0] FS_RESET_VECTOR = 16'hFFFC;

  localparam logic [FS_CNT_WIDTH-1:0] OPCNT_0 = 2'd0;
  localparam logic [FS_CNT_WIDTH-1:0] OPCNT_1 = 2'd1;
  localparam logic [FS_CNT_WIDTH-1:0] OPCNT_2 = 2'd2;

  typedef enum logic [FS_STATE_WIDTH-1:0] {
    FS_VEC_LO_ISS = 4'd0,
    FS_VEC_LO_CAP = 4'd1,
    FS_VEC_HI_ISS = 4'd2,
    FS_VEC_HI_CAP = 4'd3,
    FS_OP_ISS     = 4'd4,
    FS_OP_CAP     = 4'd5,
    FS_ARG_ISS    = 4'd6,
    FS_ARG_CAP    = 4'd7,
    FS_READY      = 4'd8,
    FS_WAIT       = 4'd9
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_operand_length.sv
// Number of operand bytes (0-2) that follow a given opcode byte.
module fetch_sequencer_operand_length
  import fetch_sequencer_pkg::*;
(
  input  logic [FS_REG_WIDTH-1:0] opcode,
  output logic [FS_CNT_WIDTH-1:0] length_c
);

  logic [2:0] bbb;
  assign bbb = opcode[4:2];

  always_comb begin
    length_c = OPCNT_0;
    case (opcode[1:0])
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) length_c = OPCNT_2;
        else                                                  length_c = OPCNT_1;
      end
      2'b10: begin
        if (bbb == 3'b011 || bbb == 3'b111)                      length_c = OPCNT_2;
        else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101) length_c = OPCNT_1;
        else                                                      length_c = OPCNT_0;
      end
      2'b00: begin
        // Row 000 mixes jump-to-subroutine, implied and immediate forms
        if (bbb == 3'b000) begin
          if (opcode == 8'h20)                                          length_c = OPCNT_2;
          else if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) length_c = OPCNT_0;
          else                                                           length_c = OPCNT_1;
        end else if (bbb == 3'b011 || bbb == 3'b111) begin
          length_c = OPCNT_2;
        end else if (bbb == 3'b010 || bbb == 3'b110) begin
          length_c = OPCNT_0;
        end else begin
          length_c = OPCNT_1;
        end
      end
      default: length_c = OPCNT_0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches the reset vector, then each opcode and its operands, and hands the
// complete instruction to the decoder with a one-cycle ready pulse.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned            REG_WIDTH    = FS_REG_WIDTH,
  parameter int unsigned            ADDR_WIDTH   = FS_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = ADDR_WIDTH'(FS_RESET_VECTOR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REG_WIDTH-1:0]    mem_data_in,
  input  logic                    get_next,
  input  logic                    pc_load,
  input  logic [ADDR_WIDTH-1:0]   pc_load_value,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    read_write,
  output logic [REG_WIDTH-1:0]    instruction_out,
  output logic [REG_WIDTH-1:0]    operand_lo,
  output logic [REG_WIDTH-1:0]    operand_hi,
  output logic [1:0]              operand_count,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic                    instruction_ready,
  output logic                    busy
);

  fs_state_e             state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            remaining;
  logic [1:0]            opcode_len_c;
  logic [1:0]            count_inc_c;
  logic [ADDR_WIDTH-1:0] pc_inc_c;
  logic [ADDR_WIDTH-1:0] vec_pc_c;
  logic [ADDR_WIDTH-1:0] wait_pc_c;

  fetch_sequencer_operand_length u_operand_length (
    .opcode   (FS_REG_WIDTH'(mem_data_in)),
    .length_c (opcode_len_c)
  );

  assign pc_inc_c    = pc + ADDR_WIDTH'(1);
  assign count_inc_c = operand_count + 2'd1;
  assign vec_pc_c    = ADDR_WIDTH'({mem_data_in, pc[REG_WIDTH-1:0]});
  assign wait_pc_c   = pc_load ? pc_load_value : pc;

  // Registered outputs are set on the transition into the state that owns them,
  // so mem_addr is already stable during every *_ISS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FS_VEC_LO_ISS;
      mem_addr          <= RESET_VECTOR;
      read_write        <= 1'b1;
      instruction_out   <= '0;
      operand_lo        <= '0;
      operand_hi        <= '0;
      operand_count     <= OPCNT_0;
      pc_out            <= '0;
      pc                <= '0;
      remaining         <= OPCNT_0;
      instruction_ready <= 1'b0;
      busy              <= 1'b1;
    end else begin
      read_write <= 1'b1;
      case (state)
        FS_VEC_LO_ISS: state <= FS_VEC_LO_CAP;
        FS_VEC_LO_CAP: begin
          pc[REG_WIDTH-1:0] <= mem_data_in;
          mem_addr          <= RESET_VECTOR + ADDR_WIDTH'(1);
          state             <= FS_VEC_HI_ISS;
        end
        FS_VEC_HI_ISS: state <= FS_VEC_HI_CAP;
        FS_VEC_HI_CAP: begin
          pc            <= vec_pc_c;
          mem_addr      <= vec_pc_c;
          pc_out        <= vec_pc_c;
          operand_lo    <= '0;
          operand_hi    <= '0;
          operand_count <= OPCNT_0;
          state         <= FS_OP_ISS;
        end
        FS_OP_ISS: state <= FS_OP_CAP;
        FS_OP_CAP: begin
          instruction_out <= mem_data_in;
          pc              <= pc_inc_c;
          remaining       <= opcode_len_c;
          if (opcode_len_c == OPCNT_0) begin
            instruction_ready <= 1'b1;
            state             <= FS_READY;
          end else begin
            mem_addr <= pc_inc_c;
            state    <= FS_ARG_ISS;
          end
        end
        FS_ARG_ISS: state <= FS_ARG_CAP;
        FS_ARG_CAP: begin
          if (operand_count == OPCNT_0) operand_lo <= mem_data_in;
          else                          operand_hi <= mem_data_in;
          operand_count <= count_inc_c;
          pc            <= pc_inc_c;
          if (count_inc_c == remaining) begin
            instruction_ready <= 1'b1;
            state             <= FS_READY;
          end else begin
            mem_addr <= pc_inc_c;
            state    <= FS_ARG_ISS;
          end
        end
        FS_READY: begin
          instruction_ready <= 1'b0;
          busy              <= 1'b0;
          state             <= FS_WAIT;
        end
        FS_WAIT: begin
          if (get_next) begin
            pc            <= wait_pc_c;
            mem_addr      <= wait_pc_c;
            pc_out        <= wait_pc_c;
            operand_lo    <= '0;
            operand_hi    <= '0;
            operand_count <= OPCNT_0;
            busy          <= 1'b1;
            state         <= FS_OP_ISS;
          end
        end
        default: begin
          mem_addr <= RESET_VECTOR;
          busy     <= 1'b1;
          state    <= FS_VEC_LO_ISS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-cycle-latency program memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_data_in;
  logic        get_next = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = '0;
  logic [15:0] mem_addr;
  logic        read_write;
  logic [7:0]  instruction_out;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [1:0]  operand_count;
  logic [15:0] pc_out;
  logic        instruction_ready;
  logic        busy;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .mem_data_in       (mem_data_in),
    .get_next          (get_next),
    .pc_load           (pc_load),
    .pc_load_value     (pc_load_value),
    .mem_addr          (mem_addr),
    .read_write        (read_write),
    .instruction_out   (instruction_out),
    .operand_lo        (operand_lo),
    .operand_hi        (operand_hi),
    .operand_count     (operand_count),
    .pc_out            (pc_out),
    .instruction_ready (instruction_ready),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_in <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 is the current cycle; counts cycles until the ready pulse is seen.
  task automatic wait_ready(input string tag, input int expected);
    int n = 1;
    while (instruction_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(expected));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  32'(mem_addr), 32'hFFFC);
    check({tag, "_rw"},    32'(read_write), 32'd1);
    check({tag, "_instr"}, 32'(instruction_out), 32'h00);
    check({tag, "_lo"},    32'(operand_lo), 32'h00);
    check({tag, "_hi"},    32'(operand_hi), 32'h00);
    check({tag, "_cnt"},   32'(operand_count), 32'd0);
    check({tag, "_pc"},    32'(pc_out), 32'h0000);
    check({tag, "_rdy"},   32'(instruction_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;
    mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
    mem[16'h8003] = 8'h8D; mem[16'h8004] = 8'h00; mem[16'h8005] = 8'h02;
    mem[16'h8006] = 8'hEA;
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h77;

    // Reset vector -> NOP at 8000
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    wait_ready("nop_lat", 7);
    check("nop_instr", 32'(instruction_out), 32'hEA);
    check("nop_cnt",   32'(operand_count), 32'd0);
    check("nop_pc",    32'(pc_out), 32'h8000);
    tick();
    check("wait_busy", 32'(busy), 32'd0);
    check("wait_rdy",  32'(instruction_ready), 32'd0);

    // Immediate operand
    get_next = 1'b1;
    tick();
    get_next = 1'b0;
    check("imm_addr", 32'(mem_addr), 32'h8001);
    check("imm_busy", 32'(busy), 32'd1);
    wait_ready("imm_lat", 5);
    check("imm_instr", 32'(instruction_out), 32'hA9);
    check("imm_lo",    32'(operand_lo), 32'h42);
    check("imm_hi",    32'(operand_hi), 32'h00);
    check("imm_cnt",   32'(operand_count), 32'd1);
    check("imm_pc",    32'(pc_out), 32'h8001);
    tick();

    // Absolute operand, get_next held high for back-to-back fetches
    get_next = 1'b1;
    tick();
    check("abs_addr", 32'(mem_addr), 32'h8003);
    wait_ready("abs_lat", 7);
    check("abs_instr", 32'(instruction_out), 32'h8D);
    check("abs_lo",    32'(operand_lo), 32'h00);
    check("abs_hi",    32'(operand_hi), 32'h02);
    check("abs_cnt",   32'(operand_count), 32'd2);
    check("abs_pc",    32'(pc_out), 32'h8003);
    tick();
    check("b2b_wait_busy", 32'(busy), 32'd0);
    tick();
    check("b2b_addr", 32'(mem_addr), 32'h8006);
    wait_ready("b2b_lat", 3);
    check("b2b_pc", 32'(pc_out), 32'h8006);
    get_next = 1'b0;
    tick();

    // Stall with a stray pc_load, then jump
    pc_load = 1'b1;
    pc_load_value = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_busy",  32'(busy), 32'd0);
      check("stall_instr", 32'(instruction_out), 32'hEA);
      check("stall_addr",  32'(mem_addr), 32'h8006);
      check("stall_rdy",   32'(instruction_ready), 32'd0);
    end
    pc_load_value = 16'hC000;
    get_next = 1'b1;
    tick();
    get_next = 1'b0;
    pc_load = 1'b0;
    check("jmp_addr", 32'(mem_addr), 32'hC000);
    check("jmp_pc",   32'(pc_out), 32'hC000);
    wait_ready("jmp_lat", 5);
    check("jmp_lo",   32'(operand_lo), 32'h77);
    check("jmp_pc2",  32'(pc_out), 32'hC000);

    // Address wrap: vector to FFFE
    mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'hA9; mem[16'h0002] = 8'h55;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("wrap_lat", 11);
    check("wrap_instr", 32'(instruction_out), 32'hAD);
    check("wrap_lo",    32'(operand_lo), 32'h34);
    check("wrap_hi",    32'(operand_hi), 32'h12);
    check("wrap_pc",    32'(pc_out), 32'hFFFE);
    tick();
    get_next = 1'b1;
    tick();
    get_next = 1'b0;
    check("wrap_next", 32'(mem_addr), 32'h0001);

    // Reset while in ARG_CAP (OP_CAP, ARG_ISS, ARG_CAP follow)
    repeat (3) tick();
    check("mid_addr", 32'(mem_addr), 32'h0002);
    check("mid_rdy",  32'(instruction_ready), 32'd0);
    reset = 1'b1;
    tick();
    check_reset_values("mid");
    reset = 1'b0;
    tick();
    check("mid_rdy2", 32'(instruction_ready), 32'd0);
    check("mid_cnt2", 32'(operand_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
